mul_issue_ctrl: RTL and testbench

- Issue and retire controller wrapped around the 32x32 pipelined Wallace-tree multiplier core. Both request and result sides use valid/ready.
- Accepts RV32M multiply requests from the execute stage and converts signed operands to magnitudes. Drives the core's start and operand inputs, and tracks in-flight metadata.
- On core valid, applies sign correction and high/low word selection, then buffers results toward writeback.
- Credit-based: the core cannot stall, so the block never issues more than the result buffer can absorb.

---
 rtl/mul_pkg.sv | 21 ++
 rtl/mul_sync_fifo.sv | 49 ++++
 rtl/mul_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_mul_issue_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the multiplier issue/retire controller: RV32M op encoding,
// core latency and the per-operation metadata carried alongside the core.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'd0,
        MUL_OP_MULH   = 2'd1,
        MUL_OP_MULHSU = 2'd2,
        MUL_OP_MULHU  = 2'd3
    } mul_op_e;

    localparam int MUL_LAT   = 6;
    localparam int MUL_TAG_W = 5;

    typedef struct packed {
        mul_op_e                op;
        logic [MUL_TAG_W-1:0]   tag;
        logic                   neg;
    } mul_meta_t;

endpackage

// File: rtl/mul_sync_fifo.sv
// Synchronous FIFO with asynchronous reset and occupancy count; read data is
// zero whenever the FIFO is empty so downstream outputs idle at zero.
module mul_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push & (count != FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/retire controller around the unsigned pipelined multiplier core.
// Optional performance counters are enabled with `define MUL_ISSUE_PERF_EN.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = MUL_TAG_W,
    parameter int DEPTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [1:0]         req_op_i,
    input  logic [WIDTH-1:0]   req_rs1_i,
    input  logic [WIDTH-1:0]   req_rs2_i,
    input  logic [TAG_W-1:0]   req_tag_i,
    output logic               mul_start_o,
    output logic [WIDTH-1:0]   mul_rs1_o,
    output logic [WIDTH-1:0]   mul_rs2_o,
    input  logic [2*WIDTH-1:0] mul_result_i,
    input  logic               mul_valid_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [WIDTH-1:0]   rsp_data_o,
`ifdef MUL_ISSUE_PERF_EN
    output logic [31:0]        perf_ops_o,
    output logic [31:0]        perf_stall_o,
`endif
    output logic [TAG_W-1:0]   rsp_tag_o
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] MAX_CREDIT = (CW+1)'(DEPTH);

    logic [CW-1:0]        meta_count;
    logic [CW-1:0]        res_count;
    logic                 meta_empty;
    logic                 res_empty;
    logic [CW:0]          credit;
    logic                 accept;
    logic                 rsp_pop;
    logic                 retire;
    mul_op_e              op;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    mul_meta_t            meta_in;
    mul_meta_t            meta_out;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     ret_data;
    logic [WIDTH+TAG_W-1:0] res_rdata;

    // Every accepted op owns a result slot until it is popped, whether it is
    // still inside the core (metadata FIFO) or waiting in the result FIFO.
    assign credit      = {1'b0, meta_count} + {1'b0, res_count};
    assign req_ready_o = ~rst_i & (credit < MAX_CREDIT);
    assign accept      = req_valid_i & req_ready_o;
    assign rsp_pop     = rsp_valid_o & rsp_ready_i;

    assign op     = mul_op_e'(req_op_i);
    assign sign_a = req_rs1_i[WIDTH-1] & ((op == MUL_OP_MULH) | (op == MUL_OP_MULHSU));
    assign sign_b = req_rs2_i[WIDTH-1] & (op == MUL_OP_MULH);
    assign mag_a  = sign_a ? (~req_rs1_i + WIDTH'(1)) : req_rs1_i;
    assign mag_b  = sign_b ? (~req_rs2_i + WIDTH'(1)) : req_rs2_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mul_start_o <= 1'b0;
            mul_rs1_o   <= '0;
            mul_rs2_o   <= '0;
        end else begin
            mul_start_o <= accept;
            if (accept) begin
                mul_rs1_o <= mag_a;
                mul_rs2_o <= mag_b;
            end
        end
    end

    assign meta_in.op  = op;
    assign meta_in.tag = req_tag_i;
    assign meta_in.neg = sign_a ^ sign_b;

    mul_sync_fifo #(
        .WIDTH ($bits(mul_meta_t)),
        .DEPTH (DEPTH)
    ) u_meta_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (accept),
        .wdata (meta_in),
        .pop   (retire),
        .rdata (meta_out),
        .count (meta_count),
        .empty (meta_empty)
    );

    // A core valid with no tracked operation is a stray and is dropped.
    assign retire   = mul_valid_i & ~meta_empty;
    assign product  = meta_out.neg ? (~mul_result_i + (2*WIDTH)'(1)) : mul_result_i;
    assign ret_data = (meta_out.op == MUL_OP_MUL) ? product[WIDTH-1:0]
                                                  : product[2*WIDTH-1:WIDTH];

    mul_sync_fifo #(
        .WIDTH (WIDTH + TAG_W),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (retire),
        .wdata ({ret_data, meta_out.tag}),
        .pop   (rsp_pop),
        .rdata (res_rdata),
        .count (res_count),
        .empty (res_empty)
    );

    assign rsp_valid_o = ~res_empty;
    assign rsp_data_o  = res_rdata[WIDTH+TAG_W-1:TAG_W];
    assign rsp_tag_o   = res_rdata[TAG_W-1:0];

`ifdef MUL_ISSUE_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_ops_o   <= '0;
            perf_stall_o <= '0;
        end else begin
            if (rsp_pop)                     perf_ops_o   <= perf_ops_o + 32'd1;
            if (req_valid_i & ~req_ready_o)  perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: a cycle model of the unsigned core
// plus an in-order scoreboard of RV32M results computed with plain arithmetic.
module tb_mul_issue_ctrl;
    import mul_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int DEPTH = 8;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [WIDTH-1:0]   req_rs1;
    logic [WIDTH-1:0]   req_rs2;
    logic [TAG_W-1:0]   req_tag;
    logic               mul_start;
    logic [WIDTH-1:0]   mul_rs1;
    logic [WIDTH-1:0]   mul_rs2;
    logic [2*WIDTH-1:0] mul_result;
    logic               mul_valid;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_data;
    logic [TAG_W-1:0]   rsp_tag;
`ifdef MUL_ISSUE_PERF_EN
    logic [31:0]        perf_ops;
    logic [31:0]        perf_stall;
`endif

    mul_issue_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_rs1_i    (req_rs1),
        .req_rs2_i    (req_rs2),
        .req_tag_i    (req_tag),
        .mul_start_o  (mul_start),
        .mul_rs1_o    (mul_rs1),
        .mul_rs2_o    (mul_rs2),
        .mul_result_i (mul_result),
        .mul_valid_i  (mul_valid),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
`ifdef MUL_ISSUE_PERF_EN
        .perf_ops_o   (perf_ops),
        .perf_stall_o (perf_stall),
`endif
        .rsp_tag_o    (rsp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: start sampled on one edge, valid shows MUL_LAT edges later.
    logic [2*WIDTH-1:0] pipe_p [MUL_LAT+1];
    logic               pipe_v [MUL_LAT+1];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= MUL_LAT; i++) pipe_v[i] <= 1'b0;
        end else begin
            pipe_v[0] <= mul_start;
            pipe_p[0] <= {32'd0, mul_rs1} * {32'd0, mul_rs2};
            for (int i = 1; i <= MUL_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_p[i] <= pipe_p[i-1];
            end
        end
    end
    assign mul_valid  = pipe_v[MUL_LAT];
    assign mul_result = pipe_p[MUL_LAT];

    int edge_count = 0;
    always @(posedge clk) edge_count <= edge_count + 1;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        int               acc_edge;
    } exp_t;

    exp_t             exp_q[$];
    int               n_checks = 0;
    int               n_fails  = 0;
    int               pop_count = 0;
    bit               last_acc;
    bit               pop_seen;
    int               last_lat;
    logic [WIDTH-1:0] last_data;
    logic [TAG_W-1:0] last_tag;
    bit               stalled_prev = 0;
    logic [WIDTH-1:0] held_data;
    logic [TAG_W-1:0] held_tag;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Reference result from the architectural definition of each RV32M op.
    function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom % 8)
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // One cycle: observe handshakes just before the edge, update the model,
    // then move on to the next falling edge where inputs may change.
    task automatic applyStimulus();
        exp_t e;
        #1;
        last_acc = req_valid && req_ready;
        pop_seen = 0;
        if (exp_q.size() == 0) checkOutput("idle_rsp_valid", rsp_valid, 0);
        if (rsp_valid && stalled_prev) begin
            checkOutput("stall_hold_data", rsp_data, held_data);
            checkOutput("stall_hold_tag", rsp_tag, held_tag);
        end
        if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("rsp_data", rsp_data, e.data);
            checkOutput("rsp_tag", rsp_tag, e.tag);
            pop_seen  = 1;
            pop_count++;
            last_lat  = edge_count - e.acc_edge;
            last_data = rsp_data;
            last_tag  = rsp_tag;
        end
        if (last_acc) begin
            e.data     = refResult(req_op, req_rs1, req_rs2);
            e.tag      = req_tag;
            e.acc_edge = edge_count + 1;
            exp_q.push_back(e);
        end
        stalled_prev = rsp_valid && !rsp_ready;
        held_data    = rsp_data;
        held_tag     = rsp_tag;
        @(negedge clk);
    endtask

    task automatic issueOne(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
        for (int i = 0; i < 50; i++) begin
            applyStimulus();
            if (last_acc) break;
        end
        checkOutput("req_accept", last_acc, 1);
        req_valid = 1'b0;
    endtask

    task automatic waitResponse();
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (pop_seen) break;
        end
        checkOutput("rsp_arrived", pop_seen, 1);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() > 0; i++) applyStimulus();
        checkOutput("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0]  ops  [12];
        logic [31:0] as   [12];
        logic [31:0] bs   [12];
        int          idx;
        int          snap;
        int          seen;
        int          acc_count;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_mul_start", mul_start, 0);
        checkOutput("reset_mul_rs1", mul_rs1, 0);
        checkOutput("reset_mul_rs2", mul_rs2, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        checkOutput("reset_rsp_tag", rsp_tag, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", req_ready, 1);
        @(negedge clk);

        $display("[TB] directed: MUL 7x6 latency");
        issueOne(2'd0, 32'd7, 32'd6, 5'd3);
        waitResponse();
        checkOutput("mul_7x6_data", last_data, 32'h0000_002A);
        checkOutput("mul_7x6_tag", last_tag, 3);
        checkOutput("mul_7x6_latency", last_lat, 8);

        $display("[TB] directed: sign corner cases");
        issueOne(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
        waitResponse();
        checkOutput("mulh_min_min", last_data, 32'h4000_0000);
        issueOne(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        waitResponse();
        checkOutput("mulhsu_ones", last_data, 32'hFFFF_FFFF);
        issueOne(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        waitResponse();
        checkOutput("mulhu_ones", last_data, 32'hFFFF_FFFE);

        $display("[TB] directed: credit limit with stalled output");
        for (int i = 0; i < 12; i++) begin
            ops[i] = 2'($urandom);
            as[i]  = pickOperand();
            bs[i]  = pickOperand();
        end
        rsp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            req_valid = (idx < 12);
            if (idx < 12) begin
                req_op  = ops[idx];
                req_rs1 = as[idx];
                req_rs2 = bs[idx];
                req_tag = 5'(idx + 8);
            end
            applyStimulus();
            if (last_acc) idx++;
        end
        checkOutput("accepted_while_stalled", idx, 8);
        #1;
        checkOutput("ready_low_when_full", req_ready, 0);
        rsp_ready = 1'b1;
        snap = pop_count;
        for (int c = 0; c < 200; c++) begin
            if (idx == 12 && exp_q.size() == 0) break;
            req_valid = (idx < 12);
            if (idx < 12) begin
                req_op  = ops[idx];
                req_rs1 = as[idx];
                req_rs2 = bs[idx];
                req_tag = 5'(idx + 8);
            end
            applyStimulus();
            if (last_acc) idx++;
        end
        req_valid = 1'b0;
        checkOutput("all_issued", idx, 12);
        checkOutput("stall_drained", exp_q.size(), 0);
        checkOutput("retired_count", pop_count - snap, 12);

        $display("[TB] directed: reset with operations in flight");
        issueOne(2'd0, 32'd11, 32'd13, 5'd20);
        issueOne(2'd1, 32'hFFFF_FFF0, 32'd3, 5'd21);
        issueOne(2'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd22);
        applyStimulus();
        applyStimulus();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_rsp_valid", rsp_valid, 0);
        checkOutput("midrst_rsp_data", rsp_data, 0);
        checkOutput("midrst_rsp_tag", rsp_tag, 0);
        checkOutput("midrst_mul_start", mul_start, 0);
        checkOutput("midrst_mul_rs1", mul_rs1, 0);
        checkOutput("midrst_req_ready", req_ready, 0);
        exp_q.delete();
        stalled_prev = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus();
            if (rsp_valid) seen++;
        end
        checkOutput("post_reset_quiet", seen, 0);
        issueOne(2'd0, 32'hFFFF_FFFD, 32'd5, 5'd9);
        waitResponse();
        checkOutput("post_reset_data", last_data, 32'hFFFF_FFF1);
        checkOutput("post_reset_tag", last_tag, 9);

        $display("[TB] random: 10000 transactions");
        acc_count = 0;
        last_acc  = 0;
        req_valid = 1'b0;
        for (int c = 0; c < 60000 && acc_count < 10000; c++) begin
            if (!req_valid || last_acc) begin
                req_valid = (($urandom % 4) != 0);
                req_op    = 2'($urandom);
                req_rs1   = pickOperand();
                req_rs2   = pickOperand();
                req_tag   = 5'($urandom);
            end
            rsp_ready = (($urandom % 4) != 0);
            applyStimulus();
            if (last_acc) acc_count++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        checkOutput("random_accepted", acc_count, 10000);
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
